// File: rtl/and_reduce_unit.sv
// Registered maskable AND-reduction with lowest-failing-bit locator.
// Optional sticky accumulator enabled by defining AND_STICKY_EN.
module and_reduce_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [WIDTH-1:0] IN_MASK,
    input  logic             INVERT,
`ifdef AND_STICKY_EN
    input  logic             STICKY_CLR,
    output logic             OUT_STICKY,
`endif
    output logic             OUT_VALID,
    output logic             OUT_AND,
    output logic [IDXW-1:0]  OUT_FAIL_IDX
);

    logic [WIDTH-1:0] masked_c;
    logic             and_c;
    logic [IDXW-1:0]  fail_idx_c;

    // Ignored lanes are forced to 1 so X/Z on them cannot reach the reduction.
    always_comb begin
        masked_c = (INVERT ? ~IN_DATA : IN_DATA) | ~IN_MASK;
        and_c    = &masked_c;
    end

    // Scan from the top down so the lowest failing lane is the one left.
    always_comb begin
        fail_idx_c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!masked_c[i]) begin
                fail_idx_c = IDXW'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_VALID    <= 1'b0;
            OUT_AND      <= 1'b0;
            OUT_FAIL_IDX <= '0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID) begin
                OUT_AND      <= and_c;
                OUT_FAIL_IDX <= fail_idx_c;
            end
        end
    end

`ifdef AND_STICKY_EN
    // Clear takes priority over accumulating a same-cycle input.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_STICKY <= 1'b1;
        end else if (STICKY_CLR) begin
            OUT_STICKY <= 1'b1;
        end else if (IN_VALID) begin
            OUT_STICKY <= OUT_STICKY & and_c;
        end
    end
`endif

endmodule

// File: tb/tb_and_reduce_unit.sv
// Directed self-checking bench for and_reduce_unit (WIDTH=8).
module tb_and_reduce_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic [7:0] IN_MASK;
    logic       INVERT;
    logic       OUT_VALID;
    logic       OUT_AND;
    logic [2:0] OUT_FAIL_IDX;
`ifdef AND_STICKY_EN
    logic       STICKY_CLR;
    logic       OUT_STICKY;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    and_reduce_unit #(.WIDTH(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IN_VALID     (IN_VALID),
        .IN_DATA      (IN_DATA),
        .IN_MASK      (IN_MASK),
        .INVERT       (INVERT),
`ifdef AND_STICKY_EN
        .STICKY_CLR   (STICKY_CLR),
        .OUT_STICKY   (OUT_STICKY),
`endif
        .OUT_VALID    (OUT_VALID),
        .OUT_AND      (OUT_AND),
        .OUT_FAIL_IDX (OUT_FAIL_IDX)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] m, input logic inv);
        IN_VALID = v;
        IN_DATA  = d;
        IN_MASK  = m;
        INVERT   = inv;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
`ifdef AND_STICKY_EN
        STICKY_CLR = 1'b0;
`endif
        step();
        step();
        RESET = 1'b0;
        step();
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", OUT_VALID); end
        n_checks++; if (OUT_AND !== 1'b0) begin n_fail++; $display("FAIL reset_and got %b want 0", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", OUT_FAIL_IDX); end
    endtask

    task automatic test_all_ones();
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL ones_valid got %b want 1", OUT_VALID); end
        n_checks++; if (OUT_AND !== 1'b1) begin n_fail++; $display("FAIL ones_and got %b want 1", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd0) begin n_fail++; $display("FAIL ones_idx got %0d want 0", OUT_FAIL_IDX); end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", OUT_VALID); end
        n_checks++; if (OUT_AND !== 1'b1) begin n_fail++; $display("FAIL idle_and_hold got %b want 1", OUT_AND); end
    endtask

    task automatic test_fail_idx();
        drive(1'b1, 8'hEB, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_AND !== 1'b0) begin n_fail++; $display("FAIL eb_and got %b want 0", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd2) begin n_fail++; $display("FAIL eb_idx got %0d want 2", OUT_FAIL_IDX); end
        drive(1'b0, 8'hFF, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_FAIL_IDX !== 3'd2) begin n_fail++; $display("FAIL idx_hold got %0d want 2", OUT_FAIL_IDX); end
        drive(1'b1, 8'hEB, 8'hEB, 1'b0);
        step();
        n_checks++; if (OUT_AND !== 1'b1) begin n_fail++; $display("FAIL eb_masked_and got %b want 1", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd0) begin n_fail++; $display("FAIL eb_masked_idx got %0d want 0", OUT_FAIL_IDX); end
        drive(1'b1, 8'h7F, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_FAIL_IDX !== 3'd7) begin n_fail++; $display("FAIL top_idx got %0d want 7", OUT_FAIL_IDX); end
    endtask

    task automatic test_zero_flag();
        drive(1'b1, 8'h00, 8'hFF, 1'b1);
        step();
        n_checks++; if (OUT_AND !== 1'b1) begin n_fail++; $display("FAIL zero_and got %b want 1", OUT_AND); end
        drive(1'b1, 8'h10, 8'hFF, 1'b1);
        step();
        n_checks++; if (OUT_AND !== 1'b0) begin n_fail++; $display("FAIL nz_and got %b want 0", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd4) begin n_fail++; $display("FAIL nz_idx got %0d want 4", OUT_FAIL_IDX); end
    endtask

    task automatic test_mask();
        drive(1'b1, 8'h5A, 8'h00, 1'b0);
        step();
        n_checks++; if (OUT_AND !== 1'b1) begin n_fail++; $display("FAIL mask0_and got %b want 1", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd0) begin n_fail++; $display("FAIL mask0_idx got %0d want 0", OUT_FAIL_IDX); end
        drive(1'b1, 8'bxzxz_1111, 8'h0F, 1'b0);
        step();
        n_checks++; if (OUT_AND !== 1'b1) begin n_fail++; $display("FAIL xmask_and got %b want 1", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd0) begin n_fail++; $display("FAIL xmask_idx got %0d want 0", OUT_FAIL_IDX); end
        drive(1'b1, 8'bxzxz_1011, 8'h0F, 1'b0);
        step();
        n_checks++; if (OUT_AND !== 1'b0) begin n_fail++; $display("FAIL xmask_fail_and got %b want 0", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd2) begin n_fail++; $display("FAIL xmask_fail_idx got %0d want 2", OUT_FAIL_IDX); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'hFE, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_VALID !== 1'b1 || OUT_FAIL_IDX !== 3'd0 || OUT_AND !== 1'b0) begin
            n_fail++; $display("FAIL b2b_0 got v=%b a=%b i=%0d want v=1 a=0 i=0", OUT_VALID, OUT_AND, OUT_FAIL_IDX); end
        drive(1'b1, 8'hDF, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_VALID !== 1'b1 || OUT_FAIL_IDX !== 3'd5 || OUT_AND !== 1'b0) begin
            n_fail++; $display("FAIL b2b_1 got v=%b a=%b i=%0d want v=1 a=0 i=5", OUT_VALID, OUT_AND, OUT_FAIL_IDX); end
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_VALID !== 1'b1 || OUT_FAIL_IDX !== 3'd0 || OUT_AND !== 1'b1) begin
            n_fail++; $display("FAIL b2b_2 got v=%b a=%b i=%0d want v=1 a=1 i=0", OUT_VALID, OUT_AND, OUT_FAIL_IDX); end
    endtask

    task automatic test_reset_override();
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        drive(1'b0, 8'h00, 8'hFF, 1'b0);
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_ovr_valid got %b want 0", OUT_VALID); end
        n_checks++; if (OUT_AND !== 1'b0) begin n_fail++; $display("FAIL rst_ovr_and got %b want 0", OUT_AND); end
        n_checks++; if (OUT_FAIL_IDX !== 3'd0) begin n_fail++; $display("FAIL rst_ovr_idx got %0d want 0", OUT_FAIL_IDX); end
        step();
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid got %b want 0", OUT_VALID); end
        drive(1'b1, 8'hF7, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_VALID !== 1'b1 || OUT_FAIL_IDX !== 3'd3) begin
            n_fail++; $display("FAIL post_rst_first got v=%b i=%0d want v=1 i=3", OUT_VALID, OUT_FAIL_IDX); end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

`ifdef AND_STICKY_EN
    task automatic test_sticky();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_checks++; if (OUT_STICKY !== 1'b1) begin n_fail++; $display("FAIL sticky_rst got %b want 1", OUT_STICKY); end
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_STICKY !== 1'b1) begin n_fail++; $display("FAIL sticky_0 got %b want 1", OUT_STICKY); end
        drive(1'b1, 8'h7F, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_STICKY !== 1'b0) begin n_fail++; $display("FAIL sticky_1 got %b want 0", OUT_STICKY); end
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        step();
        n_checks++; if (OUT_STICKY !== 1'b0) begin n_fail++; $display("FAIL sticky_2 got %b want 0", OUT_STICKY); end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        STICKY_CLR = 1'b1;
        step();
        STICKY_CLR = 1'b0;
        n_checks++; if (OUT_STICKY !== 1'b1) begin n_fail++; $display("FAIL sticky_clr got %b want 1", OUT_STICKY); end
        drive(1'b1, 8'h7F, 8'hFF, 1'b0);
        STICKY_CLR = 1'b1;
        step();
        STICKY_CLR = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++; if (OUT_STICKY !== 1'b1) begin n_fail++; $display("FAIL sticky_clr_wins got %b want 1", OUT_STICKY); end
    endtask
`endif

    initial begin
        test_reset();
        test_all_ones();
        test_fail_idx();
        test_zero_flag();
        test_mask();
        test_back_to_back();
        test_reset_override();
`ifdef AND_STICKY_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
